// File: rtl/bram_pkg.sv
// Shared types and sizing for the 32x1024 simple dual-port block RAM.
package bram_pkg;

    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_ADDR_W = 10;
    localparam int BRAM_DEPTH  = 1 << BRAM_ADDR_W;

    typedef logic [BRAM_DATA_W-1:0] bram_data_t;
    typedef logic [BRAM_ADDR_W-1:0] bram_addr_t;

    // Source currently presented on doutb
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_RAM    = 2'd1,
        SRC_BYPASS = 2'd2
    } bram_src_e;

endpackage

// File: rtl/bram_32x1024_array.sv
// Raw storage for bram_32x1024: one write port, one registered read port,
// no reset so that synthesis maps it onto block RAM. The read is read-first;
// write-first behaviour on collisions is provided by the top level.
// Optional macro BRAM_INIT_ZERO_EN: zero the whole array at power-up.
module bram_32x1024_array
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef BRAM_INIT_ZERO_EN
    logic [DATA_W-1:0] r_mem [0:DEPTH-1] = '{default: '0};
`else
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
`endif

    logic [DATA_W-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: returns pre-edge contents, holds when not enabled
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_32x1024.sv
// 32x1024 simple dual-port RAM, port A write-only, port B read-only, one clock.
// Adds reset gating of the enables, a write-first collision bypass and the
// async-reset output selection around the raw array.
// Optional macro BRAM_INIT_ZERO_EN (passed to the array): zero-initialised memory.
module bram_32x1024
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              enb,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    logic              w_we;
    logic              w_re;
    logic              w_coll;
    logic [DATA_W-1:0] w_ram_rdata;

    bram_src_e         r_src;
    bram_src_e         w_src_nxt;
    logic [DATA_W-1:0] r_byp_data;

    assign w_we   = wea & ~reset;
    assign w_re   = enb & ~reset;
    assign w_coll = w_we & w_re & (addra == addrb);

    bram_32x1024_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (addra),
        .i_wdata (dina),
        .i_re    (w_re),
        .i_raddr (addrb),
        .o_rdata (w_ram_rdata)
    );

    // Output source register and captured bypass data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src      <= SRC_ZERO;
            r_byp_data <= '0;
        end else begin
            r_src <= w_src_nxt;
            if (w_coll) begin
                r_byp_data <= dina;
            end
        end
    end

    // Next source: an enabled read picks RAM or, on collision, the written word
    always_comb begin
        w_src_nxt = r_src;
        if (w_re) begin
            w_src_nxt = w_coll ? SRC_BYPASS : SRC_RAM;
        end
    end

    // Output mux; SRC_ZERO makes doutb 0 as soon as reset asserts
    always_comb begin
        doutb = '0;
        case (r_src)
            SRC_RAM:    doutb = w_ram_rdata;
            SRC_BYPASS: doutb = r_byp_data;
            default:    doutb = '0;
        endcase
    end

endmodule

// File: tb/tb_bram_32x1024.sv
// Self-checking bench for bram_32x1024 against a behavioural memory model.
module tb_bram_32x1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        wea;
    logic [9:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [9:0]  addrb;
    logic [31:0] doutb;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [1024];
    bit          m_wr  [1024];
    logic [31:0] m_exp;
    bit          m_known;

    always #5 clk = ~clk;

    bram_32x1024 dut (
        .clk   (clk),
        .reset (reset),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .enb   (enb),
        .addrb (addrb),
        .doutb (doutb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, let the edge happen, update model, check at negedge
    task automatic cyc(input bit we, input logic [9:0] aa, input logic [31:0] da,
                       input bit re, input logic [9:0] ab, input string tag);
        wea   = we;
        addra = aa;
        dina  = da;
        enb   = re;
        addrb = ab;
        @(posedge clk);
        if (reset) begin
            m_exp   = 32'h0;
            m_known = 1'b1;
        end else begin
            if (re) begin
                if (we && aa == ab) begin
                    m_exp   = da;
                    m_known = 1'b1;
                end else begin
                    m_exp   = m_mem[ab];
                    m_known = m_wr[ab];
                end
            end
            if (we) begin
                m_mem[aa] = da;
                m_wr[aa]  = 1'b1;
            end
        end
        @(negedge clk);
        if (m_known) chk(tag, doutb, m_exp);
    endtask

    task automatic ramp(input int L);
        logic [9:0]  p0;
        logic [31:0] base;
        p0   = 10'($urandom);
        base = $urandom;
        for (int k = 0; k < L + 24; k++) begin
            cyc(1'b1, 10'(p0 + 10'(k + L - 1)), base + 32'(k), 1'b1, 10'(p0 + 10'(k)), "ramp_model");
            if (k >= L - 1) chk($sformatf("ramp_L%0d", L), doutb, base + 32'(k - L + 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = 32'h0;
`ifdef BRAM_INIT_ZERO_EN
            m_wr[i]  = 1'b1;
`else
            m_wr[i]  = 1'b0;
`endif
        end
        m_exp   = 32'h0;
        m_known = 1'b1;
        reset   = 1'b1;
        wea     = 1'b0;
        addra   = '0;
        dina    = '0;
        enb     = 1'b0;
        addrb   = '0;
        repeat (3) @(negedge clk);
        chk("reset_value", doutb, 32'h0);
        reset = 1'b0;

`ifdef BRAM_INIT_ZERO_EN
        cyc(1'b0, 10'h0, 32'h0, 1'b1, 10'h200, "init_zero_model");
        chk("init_zero", doutb, 32'h0);
`endif

        // basic write then read
        cyc(1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 10'd0, "wr5");
        cyc(1'b0, 10'd0, 32'h0, 1'b1, 10'd5, "rd5_model");
        chk("basic_rd5", doutb, 32'hDEADBEEF);

        // write-first collision at top address
        cyc(1'b1, 10'h3FF, 32'hAAAAAAAA, 1'b0, 10'd0, "wr3ff");
        cyc(1'b1, 10'h3FF, 32'h12345678, 1'b1, 10'h3FF, "coll_model");
        chk("collision", doutb, 32'h12345678);
        cyc(1'b0, 10'd0, 32'h0, 1'b1, 10'h3FF, "rd3ff_model");
        chk("after_coll", doutb, 32'h12345678);

        // different-address simultaneous access returns old contents
        cyc(1'b1, 10'd5, 32'h01020304, 1'b1, 10'h3FF, "indep_model");
        chk("indep", doutb, 32'h12345678);

        // hold with enb low
        cyc(1'b1, 10'h040, 32'h0000FFFF, 1'b0, 10'd0, "wr40");
        cyc(1'b0, 10'd0, 32'h0, 1'b1, 10'h040, "rd40_model");
        chk("rd40", doutb, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 10'd0, 32'h0, 1'b0, 10'($urandom), "hold_model");
            chk("hold", doutb, 32'h0000FFFF);
        end

        // reset mid-operation
        cyc(1'b1, 10'd7, 32'h55AA55AA, 1'b0, 10'd0, "wr7");
        cyc(1'b0, 10'd0, 32'h0, 1'b1, 10'd7, "rd7_model");
        chk("rd7", doutb, 32'h55AA55AA);
        #2;
        reset   = 1'b1;
        m_exp   = 32'h0;
        m_known = 1'b1;
        #1;
        chk("reset_async", doutb, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 10'd7, $urandom, 1'b1, 10'd7, "in_reset");
        end
        reset = 1'b0;
        cyc(1'b0, 10'd0, 32'h0, 1'b1, 10'd7, "post_reset_model");
        chk("post_reset", doutb, 32'h55AA55AA);
        cyc(1'b0, 10'd0, 32'h0, 1'b1, 10'd5, "post_reset_rd5");

        // line-delay use
        ramp(1);
        ramp(640);

        // random traffic over a narrow window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom), 10'($urandom_range(0, 15)), $urandom,
                1'($urandom), 10'($urandom_range(0, 15)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
